password_serializer: RTL and testbench

//  Transmit side of the serial password link. Latches an N-bit password and

---
 rtl/password_serializer.sv | 150 +++++++++++++++
 tb/tb_password_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/password_serializer.sv
// Transmit side of the serial password link: latches a password and shifts it
// out MSB-first, optionally repeating it with idle gap cycles between frames.
module password_serializer #(
    parameter int   PWD_WIDTH  = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_BIT   = 1'b0,
    parameter int   REP_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PWD_WIDTH-1:0] pwd_in,
    input  logic [REP_W-1:0]     repeat_n,
    input  logic                 abort,
    output logic                 out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(PWD_WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0]    BIT_LAST = BW'(PWD_WIDTH - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [REP_W-1:0] ONE_FRAME = REP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t               r_state, w_stateNext;
    logic [PWD_WIDTH-1:0] r_word, w_wordNext;
    logic [PWD_WIDTH-1:0] r_shift, w_shiftNext;
    logic [BW-1:0]        r_bitCnt, w_bitCntNext;
    logic [GW-1:0]        r_gapCnt, w_gapCntNext;
    logic [REP_W-1:0]     r_frames, w_framesNext;
    logic                 r_out, w_outNext;
    logic                 r_valid, w_validNext;
    logic                 r_busy, w_busyNext;
    logic                 r_done, w_doneNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_word   <= '0;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_gapCnt <= '0;
            r_frames <= '0;
            r_out    <= IDLE_BIT;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_word   <= w_wordNext;
            r_shift  <= w_shiftNext;
            r_bitCnt <= w_bitCntNext;
            r_gapCnt <= w_gapCntNext;
            r_frames <= w_framesNext;
            r_out    <= w_outNext;
            r_valid  <= w_validNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
        end
    end

    // The FSM leaves SHIFT on the edge that emits the final bit, so busy is kept
    // high for one extra IDLE cycle (the last bit on the line); the done pulse
    // follows it.
    always_comb begin
        w_stateNext  = r_state;
        w_wordNext   = r_word;
        w_shiftNext  = r_shift;
        w_bitCntNext = r_bitCnt;
        w_gapCntNext = r_gapCnt;
        w_framesNext = r_frames;
        w_outNext    = IDLE_BIT;
        w_validNext  = 1'b0;
        w_busyNext   = r_busy;
        w_doneNext   = 1'b0;

        if (abort && r_busy) begin
            w_stateNext  = S_IDLE;
            w_shiftNext  = '0;
            w_bitCntNext = '0;
            w_gapCntNext = '0;
            w_framesNext = '0;
            w_busyNext   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_busy) begin
                        w_busyNext = 1'b0;
                        w_doneNext = 1'b1;
                    end else if (start) begin
                        w_wordNext   = pwd_in;
                        w_shiftNext  = pwd_in;
                        w_bitCntNext = '0;
                        w_gapCntNext = '0;
                        w_framesNext = (repeat_n == '0) ? ONE_FRAME : repeat_n;
                        w_busyNext   = 1'b1;
                        w_stateNext  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    w_outNext   = r_shift[PWD_WIDTH-1];
                    w_validNext = 1'b1;
                    w_shiftNext = {r_shift[PWD_WIDTH-2:0], 1'b0};
                    if (r_bitCnt == BIT_LAST) begin
                        w_bitCntNext = '0;
                        if (r_frames != ONE_FRAME) begin
                            w_framesNext = r_frames - ONE_FRAME;
                            w_shiftNext  = r_word;
                            if (GAP_CYCLES > 0) begin
                                w_gapCntNext = '0;
                                w_stateNext  = S_GAP;
                            end
                        end else begin
                            w_framesNext = '0;
                            w_stateNext  = S_IDLE;
                        end
                    end else begin
                        w_bitCntNext = r_bitCnt + BW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        w_gapCntNext = '0;
                        w_stateNext  = S_SHIFT;
                    end else begin
                        w_gapCntNext = r_gapCnt + GW'(1);
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                    w_busyNext  = 1'b0;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_password_serializer.sv
// Directed, table-driven bench for password_serializer with default parameters
// (4-bit word, 2 gap cycles, idle level 0).
module tb_password_serializer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] pwd_in;
    logic [3:0] repeat_n;
    logic       abort;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       start;
        logic [3:0] pwd;
        logic [3:0] rep;
        logic       abort;
        logic       eOut;
        logic       eValid;
        logic       eBusy;
        logic       eDone;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] DET_CODE = 4'b1010;
    logic [3:0] detShift = '0;
    int         detRun   = 0;
    int         detHits  = 0;

    password_serializer #(
        .PWD_WIDTH (4),
        .GAP_CYCLES(2),
        .IDLE_BIT  (1'b0),
        .REP_W     (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pwd_in   (pwd_in),
        .repeat_n (repeat_n),
        .abort    (abort),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the password detector on the loopback: a frame matches when
    // an unbroken run of valid bits ends in the detector code.
    always @(negedge clk) begin
        if (out_valid) begin
            detShift = {detShift[2:0], out};
            detRun   = detRun + 1;
            if (detRun >= 4 && detShift == DET_CODE) detHits = detHits + 1;
        end else begin
            detRun = 0;
        end
    end

    task automatic addVec(input logic s, input logic [3:0] p, input logic [3:0] r, input logic a,
                          input logic eo, input logic ev, input logic eb, input logic ed);
        vec_t v;
        v.start = s; v.pwd = p; v.rep = r; v.abort = a;
        v.eOut = eo; v.eValid = ev; v.eBusy = eb; v.eDone = ed;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] p, input logic [3:0] r, input logic a);
        start    = s;
        pwd_in   = p;
        repeat_n = r;
        abort    = a;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eo, input logic ev,
                               input logic eb, input logic ed);
        checkBit({tag, " out"}, out, eo);
        checkBit({tag, " out_valid"}, out_valid, ev);
        checkBit({tag, " busy"}, busy, eb);
        checkBit({tag, " done"}, done, ed);
    endtask

    initial begin
        int hitsBefore;

        // Single frame 0101
        addVec(1, 4'b0101, 4'd1, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 1);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);
        // Two frames of 1001 with a two-cycle gap
        addVec(1, 4'b1001, 4'd2, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 1);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);
        // repeat_n=0 sends one frame; start while busy with a new word is ignored
        addVec(1, 4'b0110, 4'd0, 0,  0, 0, 1, 0);
        addVec(1, 4'b1111, 4'd3, 0,  0, 1, 1, 0);
        addVec(1, 4'b1111, 4'd3, 0,  1, 1, 1, 0);
        addVec(1, 4'b1111, 4'd3, 0,  1, 1, 1, 0);
        addVec(1, 4'b1111, 4'd3, 0,  0, 1, 1, 0);
        addVec(1, 4'b1111, 4'd3, 0,  0, 0, 0, 1);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);
        // Abort while bit 2 of frame 0 is on the line, then abort in IDLE ignored
        addVec(1, 4'b1011, 4'd3, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 1,  0, 0, 0, 0);
        addVec(0, 4'b0000, 4'd0, 1,  0, 0, 0, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);
        // Fresh frame after abort
        addVec(1, 4'b1100, 4'd1, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 1);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);
        // start together with abort in IDLE is accepted
        addVec(1, 4'b0011, 4'd1, 1,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 1);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);
        // start held high: accepted again in the done cycle
        addVec(1, 4'b1010, 4'd1, 0,  0, 0, 1, 0);
        addVec(1, 4'b1010, 4'd1, 0,  1, 1, 1, 0);
        addVec(1, 4'b1010, 4'd1, 0,  0, 1, 1, 0);
        addVec(1, 4'b1010, 4'd1, 0,  1, 1, 1, 0);
        addVec(1, 4'b1010, 4'd1, 0,  0, 1, 1, 0);
        addVec(1, 4'b1010, 4'd1, 0,  0, 0, 0, 1);
        addVec(1, 4'b1010, 4'd1, 0,  0, 0, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  1, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 1, 1, 0);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 1);
        addVec(0, 4'b0000, 4'd0, 0,  0, 0, 0, 0);

        rst_n = 1'b0;
        applyStimulus(0, 4'b0000, 4'd0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        hitsBefore = detHits;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].pwd, vecs[i].rep, vecs[i].abort);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].eOut, vecs[i].eValid,
                        vecs[i].eBusy, vecs[i].eDone);
        end

        checks++;
        if (detHits - hitsBefore != 2) begin
            failures++;
            $display("[TB] FAIL detector_hits: got %0d expected 2", detHits - hitsBefore);
        end

        // Asynchronous reset between edges in the middle of a frame
        applyStimulus(1, 4'b1111, 4'd2, 0);
        @(negedge clk);
        applyStimulus(0, 4'b0000, 4'd0, 0);
        @(negedge clk);
        checkOutput("pre_reset", 1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
